// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/forwarding logic.
//   FWD_*      : operand-mux select encodings driven on fwd_a / fwd_b
//   hz_state_t : hazard unit state as seen on the state output
//   PIPE_REG_AW: default register-address width
package pipe_pkg;

  localparam int PIPE_REG_AW = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'b00,
    HZ_LOAD_STALL = 2'b01,
    HZ_MD_WAIT    = 2'b10
  } hz_state_t;

endpackage

// File: rtl/md_busy_tracker.sv
// Multi-cycle mul/div occupancy tracker.
// A countdown loaded with MD_LAT on issue; the unit is busy while the
// count is nonzero, so an op issued in cycle t reports busy in t+1..t+MD_LAT.
//   clk, rst    : clock, synchronous active-high reset (clears the count)
//   issue_i     : a mult/div leaves ID this cycle
//   md_busy_o   : unit occupied (count nonzero)
module md_busy_tracker #(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issue_i,
  output logic md_busy_o
);

  localparam int CW = $clog2(MD_LAT + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LAT);

  logic [CW-1:0] md_cnt_q;
  logic [CW-1:0] md_cnt_d;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (issue_i) begin
      md_cnt_d = LOAD_VAL;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy_o = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard and forwarding controller.
// Drives EX operand-mux selects (fwd_a/fwd_b), the WB->ID register-file
// bypass (fwd_id_a/fwd_id_b), load-use and mul/div stalls (stall/bubble),
// and exposes mul/div occupancy, a registered state and a saturating count
// of stalled cycles.
//   Inputs : ID-stage sources/usage flags, ID_EX/EX_MEM/MEM_WB destinations
//            and write enables, id_flush for a killed ID instruction.
//   Outputs: fwd_a, fwd_b, fwd_id_a, fwd_id_b, stall, bubble, md_busy
//            (combinational, forced low while rst), state and stall_cnt
//            (registered).
// Register 0 is hardwired to zero, so it is never a forwarding source nor a
// hazard: every address match below also requires a nonzero address.
module hazard_forward_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = PIPE_REG_AW,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_uses_hilo,
  input  logic              id_md_start,
  input  logic              id_flush,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              fwd_id_a,
  output logic              fwd_id_b,
  output logic              stall,
  output logic              bubble,
  output logic              md_busy,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Writer-valid flags: a stage is a source only if it writes a nonzero reg.
  logic mem_src;
  logic wb_src;
  logic ex_src;
  assign mem_src = mem_reg_write && (mem_rd != '0);
  assign wb_src  = wb_reg_write  && (wb_rd  != '0);
  assign ex_src  = ex_reg_write  && ex_mem_read && (ex_rd != '0);

  logic load_haz;
  logic md_haz;
  logic stall_raw;
  logic md_issue;
  logic md_busy_raw;

  assign load_haz = ex_src &&
                    ((id_uses_rs && (ex_rd == id_rs)) ||
                     (id_uses_rt && (ex_rd == id_rt)));
  assign md_haz    = md_busy_raw && (id_uses_hilo || id_md_start);
  assign stall_raw = !rst && !id_flush && (load_haz || md_haz);
  // A mult/div already blocked by a busy unit (md_haz) cannot issue.
  assign md_issue  = !rst && id_md_start && !stall_raw && !id_flush;

  md_busy_tracker #(
    .MD_LAT (MD_LAT)
  ) u_md_busy_tracker (
    .clk       (clk),
    .rst       (rst),
    .issue_i   (md_issue),
    .md_busy_o (md_busy_raw)
  );

  always_comb begin
    fwd_a    = FWD_REGFILE;
    fwd_b    = FWD_REGFILE;
    fwd_id_a = 1'b0;
    fwd_id_b = 1'b0;
    stall    = 1'b0;
    bubble   = 1'b0;
    md_busy  = 1'b0;
    if (!rst) begin
      // EX_MEM holds the younger result, so it wins over MEM_WB.
      if (mem_src && (mem_rd == ex_rs)) begin
        fwd_a = FWD_EXMEM;
      end else if (wb_src && (wb_rd == ex_rs)) begin
        fwd_a = FWD_MEMWB;
      end
      if (mem_src && (mem_rd == ex_rt)) begin
        fwd_b = FWD_EXMEM;
      end else if (wb_src && (wb_rd == ex_rt)) begin
        fwd_b = FWD_MEMWB;
      end
      fwd_id_a = wb_src && (wb_rd == id_rs);
      fwd_id_b = wb_src && (wb_rd == id_rt);
      stall    = stall_raw;
      bubble   = stall_raw;
      md_busy  = md_busy_raw;
    end
  end

  hz_state_t           state_q;
  logic [CNT_W-1:0]    stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HZ_RUN;
      stall_cnt_q <= '0;
    end else begin
      // Record why the previous cycle stalled; mul/div takes precedence.
      if (stall_raw && md_haz) begin
        state_q <= HZ_MD_WAIT;
      end else if (stall_raw && load_haz) begin
        state_q <= HZ_LOAD_STALL;
      end else begin
        state_q <= HZ_RUN;
      end
      if (stall_raw && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit.
module tb_hazard_forward_unit;

  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              rst;
  logic [REG_AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic              id_uses_rs, id_uses_rt, id_uses_hilo, id_md_start, id_flush;
  logic              ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
  logic [1:0]        fwd_a, fwd_b, state;
  logic              fwd_id_a, fwd_id_b, stall, bubble, md_busy;
  logic [CNT_W-1:0]  stall_cnt;

  int tests_run;
  int tests_failed;

  hazard_forward_unit #(
    .REG_AW (REG_AW),
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_uses_hilo  (id_uses_hilo),
    .id_md_start   (id_md_start),
    .id_flush      (id_flush),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .fwd_id_a      (fwd_id_a),
    .fwd_id_b      (fwd_id_b),
    .stall         (stall),
    .bubble        (bubble),
    .md_busy       (md_busy),
    .state         (state),
    .stall_cnt     (stall_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0;
    mem_rd = '0; wb_rd = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_uses_hilo = 1'b0;
    id_md_start = 1'b0; id_flush = 1'b0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    mem_reg_write = 1'b1; mem_rd = 5'd5; ex_rs = 5'd5;
    wb_reg_write = 1'b1; wb_rd = 5'd6; id_rs = 5'd6;
    #2;
    tests_run++;
    if (fwd_a !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_fwd_a_forced: got %b expected 00", fwd_a);
    end
    tests_run++;
    if (fwd_id_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_fwd_id_a_forced: got %b expected 0", fwd_id_a);
    end
    tick();
    tick();
    rst = 1'b0;
    clear_inputs();
    #2;
    tests_run++;
    if (state !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_state: got %b expected 00", state);
    end
    tests_run++;
    if (stall_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
    end
    tests_run++;
    if (md_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_md_busy: got %b expected 0", md_busy);
    end
  endtask

  task automatic test_ex_forward();
    do_reset();
    mem_reg_write = 1'b1; mem_rd = 5'd5;
    wb_reg_write = 1'b1; wb_rd = 5'd5;
    ex_rs = 5'd5;
    #2;
    tests_run++;
    if (fwd_a !== 2'b01) begin
      tests_failed++;
      $display("FAIL fwd_a_exmem_priority: got %b expected 01", fwd_a);
    end
    mem_reg_write = 1'b0;
    #2;
    tests_run++;
    if (fwd_a !== 2'b10) begin
      tests_failed++;
      $display("FAIL fwd_a_memwb: got %b expected 10", fwd_a);
    end
    mem_reg_write = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs = 5'd0;
    #2;
    tests_run++;
    if (fwd_a !== 2'b00) begin
      tests_failed++;
      $display("FAIL fwd_a_reg0: got %b expected 00", fwd_a);
    end
    mem_rd = 5'd7; wb_rd = 5'd9; ex_rt = 5'd7; ex_rs = 5'd9;
    #2;
    tests_run++;
    if (fwd_b !== 2'b01) begin
      tests_failed++;
      $display("FAIL fwd_b_exmem: got %b expected 01", fwd_b);
    end
    tests_run++;
    if (fwd_a !== 2'b10) begin
      tests_failed++;
      $display("FAIL fwd_a_memwb_mixed: got %b expected 10", fwd_a);
    end
    ex_rt = 5'd9;
    #2;
    tests_run++;
    if (fwd_b !== 2'b10) begin
      tests_failed++;
      $display("FAIL fwd_b_memwb: got %b expected 10", fwd_b);
    end
  endtask

  task automatic test_wb_bypass();
    do_reset();
    wb_reg_write = 1'b1; wb_rd = 5'd12; id_rt = 5'd12; id_rs = 5'd3;
    #2;
    tests_run++;
    if (fwd_id_b !== 1'b1) begin
      tests_failed++;
      $display("FAIL wb_bypass_b: got %b expected 1", fwd_id_b);
    end
    tests_run++;
    if (fwd_id_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL wb_bypass_a_nomatch: got %b expected 0", fwd_id_a);
    end
    wb_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #2;
    tests_run++;
    if ({fwd_id_a, fwd_id_b} !== 2'b00) begin
      tests_failed++;
      $display("FAIL wb_bypass_reg0: got %b expected 00", {fwd_id_a, fwd_id_b});
    end
    wb_reg_write = 1'b0; wb_rd = 5'd4; id_rs = 5'd4;
    #2;
    tests_run++;
    if (fwd_id_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL wb_bypass_nowrite: got %b expected 0", fwd_id_a);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd8;
    id_rs = 5'd8; id_uses_rs = 1'b1;
    #2;
    tests_run++;
    if ({stall, bubble} !== 2'b11) begin
      tests_failed++;
      $display("FAIL load_use_stall: got %b expected 11", {stall, bubble});
    end
    tick();
    // Bubble now in ID_EX: the load is gone.
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
    #2;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_use_one_cycle: got %b expected 0", stall);
    end
    tests_run++;
    if (state !== 2'b01) begin
      tests_failed++;
      $display("FAIL load_use_state: got %b expected 01", state);
    end
    tests_run++;
    if (stall_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt);
    end
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd8; id_uses_rs = 1'b0;
    #2;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_use_unused_rs: got %b expected 0", stall);
    end
    id_rt = 5'd8; id_uses_rt = 1'b1;
    #2;
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_use_rt: got %b expected 1", stall);
    end
    ex_rd = 5'd0; id_rt = 5'd0;
    #2;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_use_reg0: got %b expected 0", stall);
    end
    tick();
    tests_run++;
    if (state !== 2'b00) begin
      tests_failed++;
      $display("FAIL load_use_back_to_run: got %b expected 00", state);
    end
  endtask

  task automatic test_md_wait();
    do_reset();
    id_md_start = 1'b1;
    #2;
    tests_run++;
    if ({stall, md_busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL md_issue_cycle: got %b expected 00", {stall, md_busy});
    end
    tick();
    id_md_start = 1'b0; id_uses_hilo = 1'b1;
    for (int k = 1; k <= MD_LAT; k++) begin
      #2;
      tests_run++;
      if ({stall, bubble, md_busy} !== 3'b111) begin
        tests_failed++;
        $display("FAIL md_stall_t%0d: got %b expected 111", k, {stall, bubble, md_busy});
      end
      tick();
    end
    #2;
    tests_run++;
    if ({stall, md_busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL md_release: got %b expected 00", {stall, md_busy});
    end
    tests_run++;
    if (stall_cnt !== 8'd4) begin
      tests_failed++;
      $display("FAIL md_stall_cnt: got %0d expected 4", stall_cnt);
    end
    tests_run++;
    if (state !== 2'b10) begin
      tests_failed++;
      $display("FAIL md_state_wait: got %b expected 10", state);
    end
    tick();
    tests_run++;
    if (state !== 2'b00) begin
      tests_failed++;
      $display("FAIL md_state_run: got %b expected 00", state);
    end
  endtask

  task automatic test_md_and_load();
    do_reset();
    id_md_start = 1'b1;
    tick();
    id_md_start = 1'b0; id_uses_hilo = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd9;
    id_rs = 5'd9; id_uses_rs = 1'b1;
    #2;
    tests_run++;
    if ({stall, bubble} !== 2'b11) begin
      tests_failed++;
      $display("FAIL both_haz_stall: got %b expected 11", {stall, bubble});
    end
    tick();
    tests_run++;
    if (state !== 2'b10) begin
      tests_failed++;
      $display("FAIL both_haz_state: got %b expected 10", state);
    end
    tests_run++;
    if (stall_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL both_haz_cnt: got %0d expected 1", stall_cnt);
    end
    id_flush = 1'b1; id_md_start = 1'b1;
    #2;
    tests_run++;
    if ({stall, bubble} !== 2'b00) begin
      tests_failed++;
      $display("FAIL flush_no_stall: got %b expected 00", {stall, bubble});
    end
    tick();
    tests_run++;
    if ({state, stall_cnt} !== {2'b00, 8'd1}) begin
      tests_failed++;
      $display("FAIL flush_state_cnt: got %b/%0d expected 00/1", state, stall_cnt);
    end
    do_reset();
    id_md_start = 1'b1; id_flush = 1'b1;
    tick();
    id_md_start = 1'b0; id_flush = 1'b0;
    #2;
    tests_run++;
    if (md_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_no_issue: got %b expected 0", md_busy);
    end
  endtask

  task automatic test_reset_mid_md();
    do_reset();
    id_md_start = 1'b1;
    tick();
    id_md_start = 1'b0; id_uses_hilo = 1'b1;
    tick();
    rst = 1'b1;
    #2;
    tests_run++;
    if ({stall, md_busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rst_forces_low: got %b expected 00", {stall, md_busy});
    end
    tick();
    rst = 1'b0;
    #2;
    tests_run++;
    if ({md_busy, stall} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rst_aborts_md: got %b expected 00", {md_busy, stall});
    end
    tests_run++;
    if (state !== 2'b00) begin
      tests_failed++;
      $display("FAIL rst_mid_state: got %b expected 00", state);
    end
    tests_run++;
    if (stall_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_cnt: got %0d expected 0", stall_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd3;
    id_rs = 5'd3; id_uses_rs = 1'b1;
    repeat (254) tick();
    tests_run++;
    if (stall_cnt !== 8'd254) begin
      tests_failed++;
      $display("FAIL sat_pre: got %0d expected 254", stall_cnt);
    end
    repeat ((1 << CNT_W) + 3 - 254) tick();
    tests_run++;
    if (stall_cnt !== 8'hFF) begin
      tests_failed++;
      $display("FAIL sat_hold: got %0d expected 255", stall_cnt);
    end
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_still_stalling: got %b expected 1", stall);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_ex_forward();
    test_wb_bypass();
    test_load_use();
    test_md_wait();
    test_md_and_load();
    test_reset_mid_md();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised successor to the 5-stage pipeline forwarding controller. It combines EX-stage operand forwarding, the WB-to-ID register-file bypass, load-use stall detection and multi-cycle mul/div busy tracking in one block. It sits beside the ID/EX pipeline registers and drives the operand-mux selects, the PC/IF_ID hold and the ID_EX bubble insert. Unlike the previous unit, it never forwards from register 0, never lets an unused source raise a hazard, and produces stalls itself.

Parameters:
REG_AW, 5, register-address width (register file depth is 2**REG_AW)
MD_LAT, 4, mul/div occupancy in cycles after issue (range 1..15)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
id_rs  in  REG_AW  rs address of the instruction in ID
id_rt  in  REG_AW  rt address of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_uses_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo)
id_md_start  in  1  ID instruction is mult/div
id_flush  in  1  ID instruction is being killed (branch taken)
ex_rs  in  REG_AW  ID_EX rs address
ex_rt  in  REG_AW  ID_EX rt address
ex_rd  in  REG_AW  ID_EX destination address
ex_reg_write  in  1  ID_EX writes the register file
ex_mem_read  in  1  ID_EX is a load
mem_rd  in  REG_AW  EX_MEM destination address
mem_reg_write  in  1  EX_MEM writes the register file
wb_rd  in  REG_AW  MEM_WB destination address
wb_reg_write  in  1  MEM_WB writes the register file
fwd_a  out  2  ALU A select: 00 regfile, 01 EX_MEM, 10 MEM_WB
fwd_b  out  2  ALU B / store-data select, same encoding as fwd_a
fwd_id_a  out  1  rs read in ID takes the WB write data
fwd_id_b  out  1  rt read in ID takes the WB write data
stall  out  1  hold PC and IF_ID
bubble  out  1  zero the ID_EX control bits
md_busy  out  1  mul/div unit occupied
state  out  2  00 RUN, 01 LOAD_STALL, 10 MD_WAIT (registered)
stall_cnt  out  CNT_W  total stalled cycles since reset, saturating

Behaviour:
- Synchronicity and polarity: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: md_cnt=0, state=RUN, stall_cnt=0. While rst=1, all combinational outputs are forced to 0.
- Address 0 is never a hazard or forward source; every address match below also requires a nonzero address.
- fwd_a = 01 when mem_reg_write and mem_rd==ex_rs. Otherwise 10 when wb_reg_write and wb_rd==ex_rs. Otherwise 00. EX_MEM has priority. fwd_b is the same rule with ex_rt.
- fwd_id_a = wb_reg_write and wb_rd==id_rs. fwd_id_b = wb_reg_write and wb_rd==id_rt. All forwarding outputs are combinational, same cycle.
- load_haz = ex_mem_read and ex_reg_write and ((id_uses_rs and ex_rd==id_rs) or (id_uses_rt and ex_rd==id_rt)).
- md_haz = md_busy and (id_uses_hilo or id_md_start).
- stall = bubble = !id_flush and (load_haz or md_haz). Both are combinational. A flushed ID instruction never stalls.
- Mul/div counter md_cnt, width $clog2(MD_LAT+1):
  - md_busy = (md_cnt != 0).
  - Issue (id_md_start and !stall and !id_flush) loads MD_LAT on the next edge.
  - Otherwise md_cnt decrements while nonzero.
  - A mult/div issued in cycle t occupies the unit through cycle t+MD_LAT. md_busy is high in cycles t+1..t+MD_LAT.
- state, registered on the next edge:
  - MD_WAIT if md_haz stalled this cycle.
  - Else LOAD_STALL if load_haz stalled this cycle.
  - Else RUN.
  - Priority is MD over LOAD.
- A load-use stall lasts exactly 1 cycle: once the bubble is in ID_EX, ex_mem_read drops.
- stall_cnt increments on every edge where stall=1 and holds at all ones.
- Reset asserted mid-operation aborts the mul/div countdown immediately (md_cnt=0 on the next edge).

Decomposition:
- Shared package pipe_pkg holds:
  - the FWD_REGFILE/FWD_EXMEM/FWD_MEMWB 2-bit constants
  - the hz_state_t encoding (RUN/LOAD_STALL/MD_WAIT)
  - the default REG_AW
- One sub-module: md_busy_tracker, containing the countdown counter and md_busy. Everything else is flat in the top.

Test Plan:
- Back-to-back ALU ops: mem_rd=5 write, wb_rd=5 write, ex_rs=5 -> fwd_a=01. Drop mem_reg_write -> fwd_a=10. Set ex_rs=0 with mem_rd=0 -> fwd_a=00.
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 -> stall=bubble=1 for 1 cycle, state=LOAD_STALL next cycle, stall_cnt=1. With id_uses_rs=0 -> stall=0.
- Mult issue at t with MD_LAT=4, then mfhi in ID at t+1 -> stall high t+1..t+4, released at t+5, md_busy falls at t+5, stall_cnt=4.
- Simultaneous load_haz and md_haz -> single stall per cycle, state=MD_WAIT. Assert id_flush in the same cycle -> stall=0, no md issue.
- WB bypass: wb_reg_write=1, wb_rd=id_rt=12 -> fwd_id_b=1, fwd_id_a=0. wb_rd=0 -> both 0.
- rst asserted at t+2 of a 4-cycle mul/div -> md_busy=0, state=RUN, stall_cnt=0 after the edge. Force stall for 2**CNT_W+3 cycles -> stall_cnt saturates at all ones.
